// File: rtl/dcache_pkg.sv
// Shared types and helpers for the direct-mapped write-through data cache.
// Byte lanes are big-endian: lane [0] carries bits 31:24.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        WACK  = 2'd3
    } state_t;

    localparam int DEF_INDEX_BITS = 4;
    localparam int WORD_OFFSET_BITS = 2;

    typedef logic [0:3][7:0] bytes_t;

    function automatic int tag_bits(input int index_bits);
        return 32 - index_bits - WORD_OFFSET_BITS;
    endfunction

    function automatic logic [31:0] pack_bytes(input bytes_t b);
        return {b[0], b[1], b[2], b[3]};
    endfunction

    function automatic bytes_t unpack_bytes(input logic [31:0] w);
        bytes_t b;
        b[0] = w[31:24];
        b[1] = w[23:16];
        b[2] = w[15:8];
        b[3] = w[7:0];
        return b;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage: combinational lookup, single synchronous write port.
// Valid bits clear asynchronously on reset; tag and data contents are don't-care until valid.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int TAG_BITS   = tag_bits(DEF_INDEX_BITS)
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic [INDEX_BITS-1:0] rd_index,
    input  logic [TAG_BITS-1:0]   rd_tag,
    output logic                  rd_hit,
    output logic [31:0]           rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [31:0]           wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tags [LINES];
    logic [31:0]         data [LINES];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_index] <= wr_tag;
            data[wr_index] <= wr_data;
        end
    end

    assign rd_hit  = valid[rd_index] && (tags[rd_index] == rd_tag);
    assign rd_data = data[rd_index];

endmodule

// File: rtl/dcache_ctrl.sv
// Write-through, no-write-allocate cache FSM; hits return same cycle, misses/stores stall MEM_LATENCY+1.
// Backpressure: stall is combinational from state and request, held until data or write ack.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS  = DEF_INDEX_BITS,
    parameter int MEM_LATENCY = 4
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic [31:0]     cpu_addr,
    input  logic [31:0]     cpu_wdata,
    input  logic            cpu_read,
    input  logic            cpu_write,
    output logic [31:0]     cpu_rdata,
    output logic            stall,
    output logic [31:0]     mem_addr,
    output logic [0:3][7:0] mem_data_in,
    input  logic [0:3][7:0] mem_data_out,
    output logic            mem_write_en,
    output logic [31:0]     hit_count,
    output logic [31:0]     miss_count
);

    localparam int TAG_BITS = tag_bits(INDEX_BITS);
    localparam int CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic                  cnt_done;
    logic [31:0]           rdata_q;

    logic [INDEX_BITS-1:0] cpu_index;
    logic [TAG_BITS-1:0]   cpu_tag;
    logic                  arr_hit;
    logic [31:0]           arr_data;
    logic                  wr_en;
    logic [INDEX_BITS-1:0] wr_index;
    logic [TAG_BITS-1:0]   wr_tag;
    logic [31:0]           wr_data;

    logic                  write_req, read_hit, read_miss;
    logic                  unused_addr_lsb;

    assign cpu_index       = cpu_addr[INDEX_BITS+1:2];
    assign cpu_tag         = cpu_addr[31:INDEX_BITS+2];
    assign unused_addr_lsb = ^cpu_addr[1:0];
    assign cnt_done        = (cnt == '0);

    // A store takes priority over a simultaneous load.
    assign write_req = (state == IDLE) && cpu_write;
    assign read_hit  = (state == IDLE) && cpu_read && !cpu_write && arr_hit;
    assign read_miss = (state == IDLE) && cpu_read && !cpu_write && !arr_hit;

    assign cpu_rdata = read_hit ? arr_data : rdata_q;

    dcache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk      (clk),
        .rst_b    (rst_b),
        .rd_index (cpu_index),
        .rd_tag   (cpu_tag),
        .rd_hit   (arr_hit),
        .rd_data  (arr_data),
        .wr_en    (wr_en),
        .wr_index (wr_index),
        .wr_tag   (wr_tag),
        .wr_data  (wr_data)
    );

    // Line write: store-hit update from the core, or fill from the registered miss address.
    always_comb begin
        wr_en    = 1'b0;
        wr_index = cpu_index;
        wr_tag   = cpu_tag;
        wr_data  = cpu_wdata;
        if (write_req && arr_hit) begin
            wr_en = 1'b1;
        end else if ((state == FILL) && cnt_done) begin
            wr_en    = 1'b1;
            wr_index = mem_addr[INDEX_BITS+1:2];
            wr_tag   = mem_addr[31:INDEX_BITS+2];
            wr_data  = pack_bytes(mem_data_out);
        end
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_write) begin
                    stall     = 1'b1;
                    state_nxt = WRITE;
                end else if (read_miss) begin
                    stall     = 1'b1;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                stall = 1'b1;
                if (cnt_done) state_nxt = IDLE;
            end
            WRITE: begin
                stall = 1'b1;
                if (cnt_done) state_nxt = WACK;
            end
            WACK: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state        <= IDLE;
            cnt          <= '0;
            mem_addr     <= '0;
            mem_data_in  <= '0;
            mem_write_en <= 1'b0;
            rdata_q      <= '0;
            hit_count    <= '0;
            miss_count   <= '0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && (state_nxt != IDLE)) begin
                cnt      <= CNT_LOAD;
                mem_addr <= {cpu_addr[31:2], 2'b00};
            end else if (((state == FILL) || (state == WRITE)) && !cnt_done) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (write_req) begin
                mem_data_in  <= unpack_bytes(cpu_wdata);
                mem_write_en <= 1'b1;
            end else if ((state == WRITE) && cnt_done) begin
                mem_write_en <= 1'b0;
            end
            if (read_hit) begin
                rdata_q   <= arr_data;
                hit_count <= hit_count + 32'd1;
            end
            if (read_miss) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scenario bench for dcache_ctrl with a latency-aware memory model and a read-data scoreboard.
module tb_dcache_ctrl;
    import dcache_pkg::*;

    localparam int L = 4;

    logic            clk = 1'b0;
    logic            rst_b = 1'b1;
    logic [31:0]     cpu_addr = '0;
    logic [31:0]     cpu_wdata = '0;
    logic            cpu_read = 1'b0;
    logic            cpu_write = 1'b0;
    logic [31:0]     cpu_rdata;
    logic            stall;
    logic [31:0]     mem_addr;
    logic [0:3][7:0] mem_data_in;
    logic [0:3][7:0] mem_data_out;
    logic            mem_write_en;
    logic [31:0]     hit_count;
    logic [31:0]     miss_count;

    int nvec = 0;
    int nerr = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    logic [31:0] sb_q [$];

    always #5 clk = ~clk;

    dcache_ctrl #(.INDEX_BITS(4), .MEM_LATENCY(L)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_read     (cpu_read),
        .cpu_write    (cpu_write),
        .cpu_rdata    (cpu_rdata),
        .stall        (stall),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_write_en (mem_write_en),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    // Memory: data only becomes valid L-1 edges after mem_addr changes, so early capture reads garbage.
    logic [31:0]  wmem [0:255];
    logic [255:0] written = '0;
    logic [31:0]  last_addr = '0;
    int           age = 0;
    logic [31:0]  rd_word;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        case (a)
            32'h0000_0040: return 32'hDEAD_BEEF;
            32'h0000_0080: return 32'hCAFE_F00D;
            32'h0000_0200: return 32'hA5A5_5A5A;
            default:       return a ^ 32'h5A00_0000;
        endcase
    endfunction

    always_comb begin
        rd_word = 32'hBAD0_BAD0;
        if (age >= L - 1) begin
            rd_word = written[mem_addr[9:2]] ? wmem[mem_addr[9:2]] : init_word(mem_addr);
        end
    end
    assign mem_data_out = rd_word;

    always @(posedge clk) begin
        if (mem_write_en) begin
            wmem[mem_addr[9:2]]    <= mem_data_in;
            written[mem_addr[9:2]] <= 1'b1;
        end
        if (mem_addr != last_addr) begin
            last_addr <= mem_addr;
            age       <= 1;
        end else if (age < 15) begin
            age <= age + 1;
        end
    end

    task automatic do_read(input logic [31:0] addr, input logic [31:0] exp, input bit miss,
                           input string nm);
        int sc;
        bit done;
        logic [31:0] want;
        sb_q.push_back(exp);
        exp_hits++;
        if (miss) exp_misses++;
        cpu_addr  = addr;
        cpu_read  = 1'b1;
        cpu_write = 1'b0;
        sc   = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!stall) done = 1'b1;
            else begin
                sc++;
                @(posedge clk); #1;
            end
        end
        want = sb_q.pop_front();
        nvec++;
        if (!done) begin
            nerr++;
            $display("FAIL %s_timeout: stall still %b after 40 cycles, required 0", nm, stall);
        end else begin
            nvec++;
            if (cpu_rdata !== want) begin
                nerr++;
                $display("FAIL %s_rdata: got %h, required %h", nm, cpu_rdata, want);
            end
            nvec++;
            if (sc != (miss ? L + 1 : 0)) begin
                nerr++;
                $display("FAIL %s_stall_cycles: got %0d, required %0d", nm, sc, miss ? L + 1 : 0);
            end
        end
        @(posedge clk); #1;
        cpu_read = 1'b0;
        nvec++;
        if (hit_count !== 32'(exp_hits)) begin
            nerr++;
            $display("FAIL %s_hit_count: got %0d, required %0d", nm, hit_count, exp_hits);
        end
        nvec++;
        if (miss_count !== 32'(exp_misses)) begin
            nerr++;
            $display("FAIL %s_miss_count: got %0d, required %0d", nm, miss_count, exp_misses);
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input bit also_read,
                            input string nm);
        int sc, mew;
        bit done;
        cpu_addr  = addr;
        cpu_wdata = data;
        cpu_write = 1'b1;
        cpu_read  = also_read;
        sc   = 0;
        mew  = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!stall) done = 1'b1;
            else begin
                sc++;
                if (mem_write_en) begin
                    mew++;
                    if (mew == 1) begin
                        nvec++;
                        if (mem_data_in !== data || mem_addr !== {addr[31:2], 2'b00}) begin
                            nerr++;
                            $display("FAIL %s_mem_bus: got addr %h data %h, required addr %h data %h",
                                     nm, mem_addr, mem_data_in, {addr[31:2], 2'b00}, data);
                        end
                    end
                end
                @(posedge clk); #1;
            end
        end
        nvec++;
        if (!done) begin
            nerr++;
            $display("FAIL %s_timeout: stall still %b after 40 cycles, required 0", nm, stall);
        end else begin
            nvec++;
            if (mem_write_en !== 1'b0) begin
                nerr++;
                $display("FAIL %s_wack_we: got %b, required 0", nm, mem_write_en);
            end
            nvec++;
            if (sc != L + 1 || mew != L) begin
                nerr++;
                $display("FAIL %s_cycles: stall %0d we %0d, required stall %0d we %0d",
                         nm, sc, mew, L + 1, L);
            end
        end
        @(posedge clk); #1;
        cpu_write = 1'b0;
        cpu_read  = 1'b0;
        nvec++;
        if (hit_count !== 32'(exp_hits) || miss_count !== 32'(exp_misses)) begin
            nerr++;
            $display("FAIL %s_counters: got hit %0d miss %0d, required hit %0d miss %0d",
                     nm, hit_count, miss_count, exp_hits, exp_misses);
        end
    endtask

    task automatic test_reset();
        #1 rst_b = 1'b0;
        #2;
        nvec++;
        if (stall !== 1'b0 || mem_write_en !== 1'b0 || mem_addr !== 32'h0 || mem_data_in !== 32'h0
            || cpu_rdata !== 32'h0 || hit_count !== 32'h0 || miss_count !== 32'h0) begin
            nerr++;
            $display("FAIL reset_outputs: stall %b we %b addr %h din %h rdata %h hit %0d miss %0d, required all 0",
                     stall, mem_write_en, mem_addr, mem_data_in, cpu_rdata, hit_count, miss_count);
        end
        cpu_addr = 32'h40;
        cpu_read = 1'b1;
        #1;
        nvec++;
        if (stall !== 1'b1) begin
            nerr++;
            $display("FAIL reset_stall_on_request: got %b, required 1", stall);
        end
        cpu_read = 1'b0;
        @(posedge clk); #1;
        rst_b = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_cold_read();
        do_read(32'h0000_0040, 32'hDEAD_BEEF, 1'b1, "cold_read");
    endtask

    task automatic test_rehit();
        do_read(32'h0000_0040, 32'hDEAD_BEEF, 1'b0, "rehit");
        nvec++;
        if (mem_addr !== 32'h0000_0040) begin
            nerr++;
            $display("FAIL rehit_mem_addr: got %h, required %h", mem_addr, 32'h40);
        end
        do_read(32'h0000_0043, 32'hDEAD_BEEF, 1'b0, "rehit_lsb");
    endtask

    task automatic test_conflict();
        do_read(32'h0000_0080, 32'hCAFE_F00D, 1'b1, "conflict_80");
        do_read(32'h0000_0040, 32'hDEAD_BEEF, 1'b1, "conflict_40");
    endtask

    task automatic test_store_hit();
        do_write(32'h0000_0040, 32'h1234_5678, 1'b0, "store_hit");
        do_read(32'h0000_0040, 32'h1234_5678, 1'b0, "store_hit_read");
    endtask

    task automatic test_store_no_allocate();
        do_write(32'h0000_0100, 32'h1234_5678, 1'b1, "store_miss");
        do_read(32'h0000_0040, 32'h1234_5678, 1'b0, "store_miss_line_kept");
        do_read(32'h0000_0100, 32'h1234_5678, 1'b1, "store_miss_read");
    endtask

    task automatic test_reset_in_fill();
        cpu_addr = 32'h0000_0200;
        cpu_read = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        nvec++;
        if (stall !== 1'b1 || mem_addr !== 32'h0000_0200) begin
            nerr++;
            $display("FAIL fill_in_progress: stall %b addr %h, required stall 1 addr 00000200",
                     stall, mem_addr);
        end
        rst_b    = 1'b0;
        cpu_read = 1'b0;
        #1;
        nvec++;
        if (stall !== 1'b0 || mem_write_en !== 1'b0 || mem_addr !== 32'h0 || mem_data_in !== 32'h0) begin
            nerr++;
            $display("FAIL abort_mem: stall %b we %b addr %h din %h, required all 0",
                     stall, mem_write_en, mem_addr, mem_data_in);
        end
        nvec++;
        if (cpu_rdata !== 32'h0 || hit_count !== 32'h0 || miss_count !== 32'h0) begin
            nerr++;
            $display("FAIL abort_core: rdata %h hit %0d miss %0d, required all 0",
                     cpu_rdata, hit_count, miss_count);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_b      = 1'b1;
        exp_hits   = 0;
        exp_misses = 0;
        @(posedge clk); #1;
        do_read(32'h0000_0200, 32'hA5A5_5A5A, 1'b1, "post_reset_read");
        do_read(32'h0000_0040, 32'h1234_5678, 1'b1, "post_reset_invalid");
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_rehit();
        test_conflict();
        test_store_hit();
        test_store_no_allocate();
        test_reset_in_fill();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the single-cycle core's ALU/regfile datapath and the byte-lane main memory.
- Hits return data combinationally in the same cycle.
- Misses and all stores stall the core while a fixed-latency memory access completes.
- Also provides hit and miss counters for performance checks.

Parameters:
- INDEX_BITS, 4, log2 of line count (16 one-word lines).
- MEM_LATENCY, 4, memory access cycles; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst_b  in  1  asynchronous reset, active-low
- cpu_addr  in  32  byte address from the ALU result
- cpu_wdata  in  32  store data (regfile rt)
- cpu_read  in  1  load request
- cpu_write  in  1  store request
- cpu_rdata  out  32  load data to the writeback mux
- stall  out  1  core must hold PC and suppress register writes
- mem_addr  out  32  word-aligned memory address
- mem_data_in  out  4x8  store bytes to memory; [0] = bits 31:24
- mem_data_out  in  4x8  load bytes from memory; [0] = bits 31:24
- mem_write_en  out  1  memory write strobe
- hit_count  out  32  read hits since reset
- miss_count  out  32  read misses since reset

Behaviour:
- Address fields:
  - index = cpu_addr[INDEX_BITS+1:2]
  - tag = cpu_addr[31:INDEX_BITS+2]
  - bits [1:0] are ignored; mem_addr[1:0] is always 0.
- Reset (asynchronous, takes effect immediately):
  - all valid bits cleared; state IDLE; latency counter 0
  - mem_write_en 0, mem_addr 0, mem_data_in all 0
  - cpu_rdata 0, hit_count 0, miss_count 0
  - stall 0 unless a request is present (stall is combinational from state and inputs)
  - Reset during FILL or WRITE aborts the access: no line is updated and mem_write_en drops at once.
- States: IDLE, FILL, WRITE, WACK.
- IDLE, read hit (valid and tag match):
  - cpu_rdata = line data combinationally; stall 0; hit_count increments at the edge.
- IDLE, read miss:
  - stall 1 combinationally; miss_count increments.
  - Register mem_addr = {cpu_addr[31:2], 2'b00}; load counter; go to FILL.
- FILL:
  - stall 1 for MEM_LATENCY cycles.
  - On the edge ending the last FILL cycle, capture mem_data_out into the line, set tag and valid, go to IDLE.
  - The replayed read then hits and is counted as a hit.
  - Read-miss stall is MEM_LATENCY+1 cycles.
- IDLE with cpu_write (write wins if cpu_read is also 1):
  - stall 1; register mem_addr, mem_data_in = cpu_wdata bytes, mem_write_en 1; go to WRITE.
  - On a hit, update the line data at this same edge. On a miss, leave the array untouched.
- WRITE:
  - mem_write_en and stall held at 1 for MEM_LATENCY cycles, then go to WACK.
- WACK:
  - one cycle; stall 0; mem_write_en 0; go to IDLE. The core retires the store at this edge.
  - The store is not re-issued, because WACK ignores cpu_write.
  - Store stall is MEM_LATENCY+1 cycles.
- No request in IDLE: stall 0; cpu_rdata holds its last value; no memory activity.
- Counters wrap modulo 2^32.
- The latency counter is a ceil-log2 down-counter; it never underflows.
- Memory contract: read data is valid MEM_LATENCY cycles after mem_addr is registered; writes commit by the end of WRITE.

Decomposition:
- Package dcache_pkg holds:
  - state enum
  - tag/index width localparams derived from INDEX_BITS
  - functions pack_bytes (4x8 to 32) and unpack_bytes (32 to 4x8), big-endian lane order
- Sub-module dcache_array holds:
  - tag, valid and data arrays
  - one combinational read port and one synchronous write port
  - async valid clear on rst_b
- dcache_ctrl holds the FSM, counters and memory-side registers.

Test Plan:
- Cold read of 0x0000_0040, memory word 0xDEAD_BEEF, MEM_LATENCY=4 -> stall high 5 cycles, cpu_rdata 0xDEAD_BEEF, miss_count 1, hit_count 1.
- Re-read 0x0000_0040 -> stall 0 same cycle, cpu_rdata 0xDEAD_BEEF, hit_count 2, no mem_addr change.
- Conflict: read 0x0000_0040 then 0x0000_0080 (same index 0) -> second read misses; re-read 0x40 misses again; miss_count 3.
- Store 0x1234_5678 to cached 0x40 -> mem_write_en high 4 cycles, mem_data_in = {12,34,56,78}, stall drops in WACK; following read hits and returns 0x1234_5678.
- Store to uncached 0x0000_0100, then read it -> write goes to memory with no allocate; read misses and returns 0x1234_5678 from memory.
- Assert rst_b=0 in the 2nd FILL cycle -> mem outputs 0 and stall 0 immediately; after release, the same read misses again and counters restart from 0.
